// File: rtl/voice_allocator.sv
// Note-event scheduler for the synth's NoteOn registers (scope 2'b10, parameter 6'h00).
// Maps note-on/note-off events onto voices, hands assignments to the phase-step loader and
// issues the kill / gap / start register-write sequences.
// Optional feature: define VOICE_STEAL_EN to steal voices round-robin when all are busy;
// otherwise such a note-on is dropped.
module voice_allocator #(
  parameter int unsigned NUM_VOICES    = 32,
  parameter int unsigned RETRIGGER_GAP = 256
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_EventValid,
  output logic        o_EventReady,
  input  logic        i_EventNoteOn,
  input  logic [6:0]  i_EventNote,
  output logic        o_AssignValid,
  input  logic        i_AssignReady,
  output logic [4:0]  o_AssignVoice,
  output logic [6:0]  o_AssignNote,
  output logic        o_RegisterWriteEnable,
  output logic [15:0] o_RegisterNumber,
  output logic [7:0]  o_RegisterValue,
  output logic        o_Dropped
);

  localparam int unsigned     GapW      = $clog2(RETRIGGER_GAP + 1);
  localparam logic [4:0]      LastVoice = 5'(NUM_VOICES - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(RETRIGGER_GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StScan, StDecide, StKill, StGap, StAssign, StStart
  } state_e;

  state_e          r_State, w_NextState;
  logic            r_EvNoteOn;
  logic [6:0]      r_EvNote;
  logic [4:0]      r_ScanIdx;
  logic            r_MatchFound, r_FreeFound;
  logic [4:0]      r_MatchVoice, r_FreeVoice;
  logic [4:0]      r_Target, w_Target;
  logic            r_Restart, w_Restart;
  logic [GapW-1:0] r_GapCount;
  logic [NUM_VOICES-1:0] r_Active;
  logic [6:0]      r_Note [NUM_VOICES];
  logic [4:0]      r_AssignVoice;
  logic [6:0]      r_AssignNote;
  logic            w_Drop;
`ifdef VOICE_STEAL_EN
  logic [4:0]      r_StealPtr;
  logic            w_Steal;
`endif

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_State <= StIdle;
    else         r_State <= w_NextState;
  end

  // Next-state decode, voice selection at DECIDE and all handshake/write outputs.
  always_comb begin
    w_NextState           = r_State;
    w_Target              = r_Target;
    w_Restart             = r_Restart;
    w_Drop                = 1'b0;
`ifdef VOICE_STEAL_EN
    w_Steal               = 1'b0;
`endif
    o_EventReady          = 1'b0;
    o_AssignValid         = 1'b0;
    o_RegisterWriteEnable = 1'b0;
    o_RegisterNumber      = 16'h0000;
    o_RegisterValue       = 8'h00;
    unique case (r_State)
      StIdle: begin
        o_EventReady = 1'b1;
        if (i_EventValid) w_NextState = StScan;
      end
      StScan: begin
        if (r_ScanIdx == LastVoice) w_NextState = StDecide;
      end
      StDecide: begin
        if (!r_EvNoteOn) begin
          if (r_MatchFound) begin
            w_Target    = r_MatchVoice;
            w_Restart   = 1'b0;
            w_NextState = StKill;
          end else begin
            w_Drop      = 1'b1;
            w_NextState = StIdle;
          end
        end else if (r_MatchFound) begin
          // Retrigger: the voice must fall silent before it restarts.
          w_Target    = r_MatchVoice;
          w_Restart   = 1'b1;
          w_NextState = StKill;
        end else if (r_FreeFound) begin
          w_Target    = r_FreeVoice;
          w_Restart   = 1'b0;
          w_NextState = StAssign;
        end else begin
`ifdef VOICE_STEAL_EN
          w_Target    = r_StealPtr;
          w_Restart   = 1'b1;
          w_Steal     = 1'b1;
          w_NextState = StKill;
`else
          w_Drop      = 1'b1;
          w_NextState = StIdle;
`endif
        end
      end
      StKill: begin
        o_RegisterWriteEnable = 1'b1;
        o_RegisterNumber      = {2'b10, 6'h00, 3'b000, r_Target};
        o_RegisterValue       = 8'h00;
        w_NextState           = r_Restart ? StGap : StIdle;
      end
      StGap: begin
        if (r_GapCount == GapLast) w_NextState = StAssign;
      end
      StAssign: begin
        o_AssignValid = 1'b1;
        if (i_AssignReady) w_NextState = StStart;
      end
      StStart: begin
        o_RegisterWriteEnable = 1'b1;
        o_RegisterNumber      = {2'b10, 6'h00, 3'b000, r_Target};
        o_RegisterValue       = 8'h01;
        w_NextState           = StIdle;
      end
      default: w_NextState = StIdle;
    endcase
    o_Dropped = w_Drop;
  end

  // Event capture and the one-voice-per-cycle match/free scan.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_EvNoteOn   <= 1'b0;
      r_EvNote     <= 7'd0;
      r_ScanIdx    <= 5'd0;
      r_MatchFound <= 1'b0;
      r_FreeFound  <= 1'b0;
      r_MatchVoice <= 5'd0;
      r_FreeVoice  <= 5'd0;
    end else if (r_State == StIdle && i_EventValid) begin
      r_EvNoteOn   <= i_EventNoteOn;
      r_EvNote     <= i_EventNote;
      r_ScanIdx    <= 5'd0;
      r_MatchFound <= 1'b0;
      r_FreeFound  <= 1'b0;
    end else if (r_State == StScan) begin
      if (r_Active[r_ScanIdx] && r_Note[r_ScanIdx] == r_EvNote && !r_MatchFound) begin
        r_MatchFound <= 1'b1;
        r_MatchVoice <= r_ScanIdx;
      end
      if (!r_Active[r_ScanIdx] && !r_FreeFound) begin
        r_FreeFound <= 1'b1;
        r_FreeVoice <= r_ScanIdx;
      end
      r_ScanIdx <= r_ScanIdx + 5'd1;
    end
  end

  // Chosen voice, gap timer and the held assignment outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Target      <= 5'd0;
      r_Restart     <= 1'b0;
      r_GapCount    <= '0;
      r_AssignVoice <= 5'd0;
      r_AssignNote  <= 7'd0;
    end else begin
      r_Target  <= w_Target;
      r_Restart <= w_Restart;
      if (r_State == StGap) begin
        r_GapCount <= (r_GapCount == GapLast) ? '0 : r_GapCount + GapW'(1);
      end
      if (r_State != StAssign && w_NextState == StAssign) begin
        r_AssignVoice <= w_Target;
        r_AssignNote  <= r_EvNote;
      end
    end
  end

  // Per-voice active bit and held note.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Active <= '0;
      for (int i = 0; i < NUM_VOICES; i++) r_Note[i] <= 7'd0;
    end else if (r_State == StKill) begin
      r_Active[r_Target] <= 1'b0;
    end else if (r_State == StAssign && i_AssignReady) begin
      r_Active[r_Target] <= 1'b1;
      r_Note[r_Target]   <= r_EvNote;
    end
  end

`ifdef VOICE_STEAL_EN
  // Round-robin steal pointer, advanced each time a voice is stolen.
  always_ff @(posedge i_Clock) begin
    if (i_Reset)      r_StealPtr <= 5'd0;
    else if (w_Steal) r_StealPtr <= (r_StealPtr == LastVoice) ? 5'd0 : r_StealPtr + 5'd1;
  end
`endif

  assign o_AssignVoice = r_AssignVoice;
  assign o_AssignNote  = r_AssignNote;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios with literal expectations plus
// randomized events checked every cycle against a timeline-level reference model.
module tb_voice_allocator;

  localparam int NV  = 32;
  localparam int GAP = 256;

  logic        clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_note = 7'd0;
  logic        ar = 1'b0;
  logic        o_EventReady, o_AssignValid, o_RegisterWriteEnable, o_Dropped;
  logic [4:0]  o_AssignVoice;
  logic [6:0]  o_AssignNote;
  logic [15:0] o_RegisterNumber;
  logic [7:0]  o_RegisterValue;

  always #5 clk = ~clk;

  voice_allocator #(.NUM_VOICES(NV), .RETRIGGER_GAP(GAP)) dut (
    .i_Clock              (clk),
    .i_Reset              (i_Reset),
    .i_EventValid         (ev_valid),
    .o_EventReady         (o_EventReady),
    .i_EventNoteOn        (ev_on),
    .i_EventNote          (ev_note),
    .o_AssignValid        (o_AssignValid),
    .i_AssignReady        (ar),
    .o_AssignVoice        (o_AssignVoice),
    .o_AssignNote         (o_AssignNote),
    .o_RegisterWriteEnable(o_RegisterWriteEnable),
    .o_RegisterNumber     (o_RegisterNumber),
    .o_RegisterValue      (o_RegisterValue),
    .o_Dropped            (o_Dropped)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit ar_mode = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (job timeline relative to the handshake) ----------------
  typedef enum int {KNone, KDrop, KKill, KFree, KRetrig} kind_e;
  bit    m_live = 1'b0;
  bit    m_act [NV];
  int    m_note[NV];
  int    m_ptr;
  kind_e m_kind = KNone;
  int    m_t, m_s, m_v, m_n, m_lastv, m_lastn;
  bit    m_sseen;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i]  = 1'b0;
      m_note[i] = 0;
    end
    m_ptr = 0; m_kind = KNone; m_lastv = 0; m_lastn = 0; m_sseen = 1'b0;
  endtask

  task automatic decide(input bit on, input int note);
    int match, free;
    match = -1; free = -1;
    for (int i = 0; i < NV; i++) begin
      if (m_act[i] && m_note[i] == note && match < 0) match = i;
      if (!m_act[i] && free < 0) free = i;
    end
    m_n = note;
    if (!on) begin
      if (match >= 0) begin m_kind = KKill; m_v = match; m_act[match] = 1'b0; end
      else m_kind = KDrop;
    end else if (match >= 0) begin
      m_kind = KRetrig; m_v = match;
    end else if (free >= 0) begin
      m_kind = KFree; m_v = free; m_act[free] = 1'b1; m_note[free] = note;
    end else begin
`ifdef VOICE_STEAL_EN
      m_kind = KRetrig; m_v = m_ptr; m_note[m_ptr] = note; m_ptr = (m_ptr + 1) % NV;
`else
      m_kind = KDrop;
`endif
    end
  endtask

  task automatic compare_step();
    int d, e_val;
    bit e_rdy, e_av, e_we, e_drop;
    if (m_live) begin
      d = cyc - m_t;
      case (m_kind)
        KDrop:         if (d >= 34) m_kind = KNone;
        KKill:         if (d >= 35) m_kind = KNone;
        KFree, KRetrig: if (m_sseen && cyc >= m_s + 2) m_kind = KNone;
        default: ;
      endcase
      e_rdy  = (m_kind == KNone);
      e_drop = (m_kind == KDrop && d == 33);
      e_we   = ((m_kind == KKill || m_kind == KRetrig) && d == 34) ||
               ((m_kind == KFree || m_kind == KRetrig) && m_sseen && cyc == m_s + 1);
      e_val  = (m_sseen && cyc == m_s + 1) ? 1 : 0;
      e_av   = (m_kind == KFree && d >= 34 && !m_sseen) ||
               (m_kind == KRetrig && d >= 35 + GAP && !m_sseen);
      if (e_av) begin m_lastv = m_v; m_lastn = m_n; end
      check("m_ready", o_EventReady, e_rdy);
      check("m_assign_valid", o_AssignValid, e_av);
      check("m_write_en", o_RegisterWriteEnable, e_we);
      check("m_dropped", o_Dropped, e_drop);
      check("m_assign_voice", o_AssignVoice, m_lastv);
      check("m_assign_note", o_AssignNote, m_lastn);
      if (e_we) begin
        check("m_reg_number", o_RegisterNumber, 32'h8000 | m_v);
        check("m_reg_value", o_RegisterValue, e_val);
      end
      if (!i_Reset) begin
        if (e_rdy && ev_valid) begin
          m_t = cyc; m_sseen = 1'b0;
          decide(ev_on, int'(ev_note));
        end else if (e_av && ar) begin
          m_s = cyc; m_sseen = 1'b1;
        end
      end
    end
    if (i_Reset) begin
      model_reset();
      m_live = 1'b1;
    end
  endtask

  initial forever begin
    @(negedge clk);
    compare_step();
  end

  // ---------------- stimulus helpers ----------------
  initial forever begin
    @(posedge clk);
    #1;
    ar = ar_mode ? 1'b1 : 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    i_Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_Reset = 1'b0;
  endtask

  task automatic send(input bit on, input int note, output int t);
    bit acc;
    acc = 1'b0; t = 0;
    @(posedge clk); #1;
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(note);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (o_EventReady && !i_Reset) begin acc = 1'b1; t = cyc; break; end
    end
    @(posedge clk); #1;
    ev_valid = 1'b0;
    if (!acc) check("event_accept_timeout", 0, 1);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (o_EventReady) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  // ---------------- directed scenarios, then random traffic ----------------
  initial begin
    int t, wcnt, rnd_note;
    bit rnd_on;
    ar_mode = 1'b1;
    do_reset();
    @(negedge clk);
    check("reset_ready", o_EventReady, 1);
    check("reset_assign_valid", o_AssignValid, 0);
    check("reset_write_en", o_RegisterWriteEnable, 0);
    check("reset_dropped", o_Dropped, 0);

    // Free-voice note-on with the loader always ready.
    send(1, 60, t);
    wait_to(t + 34);
    check("on60_valid", o_AssignValid, 1);
    check("on60_voice", o_AssignVoice, 0);
    check("on60_note", o_AssignNote, 60);
    wait_to(t + 35);
    check("on60_we", o_RegisterWriteEnable, 1);
    check("on60_num", o_RegisterNumber, 16'h8000);
    check("on60_val", o_RegisterValue, 8'h01);
    wait_to(t + 36);
    check("on60_ready", o_EventReady, 1);

    // Note-off of a held note, then reuse of the freed voice.
    send(1, 62, t); wait_idle();
    send(0, 62, t);
    wait_to(t + 34);
    check("off62_we", o_RegisterWriteEnable, 1);
    check("off62_num", o_RegisterNumber, 16'h8001);
    check("off62_val", o_RegisterValue, 8'h00);
    wait_idle();
    send(1, 64, t);
    wait_to(t + 34);
    check("on64_voice", o_AssignVoice, 1);
    check("on64_note", o_AssignNote, 64);
    wait_idle();

    // Retrigger of note 60 on voice 0: kill, 256 silent cycles, restart.
    send(1, 60, t);
    wait_to(t + 34);
    check("retrig_kill_we", o_RegisterWriteEnable, 1);
    check("retrig_kill_num", o_RegisterNumber, 16'h8000);
    check("retrig_kill_val", o_RegisterValue, 8'h00);
    wait_to(t + 35);
    wcnt = 0;
    for (int i = 0; i < GAP; i++) begin
      if (o_RegisterWriteEnable || o_AssignValid) wcnt++;
      @(negedge clk);
    end
    check("retrig_gap_quiet", wcnt, 0);
    check("retrig_assign_valid", o_AssignValid, 1);
    check("retrig_assign_voice", o_AssignVoice, 0);
    @(negedge clk);
    check("retrig_start_we", o_RegisterWriteEnable, 1);
    check("retrig_start_val", o_RegisterValue, 8'h01);
    wait_idle();

    // Unmatched note-off.
    send(0, 70, t);
    wait_to(t + 33);
    check("off70_dropped", o_Dropped, 1);
    check("off70_no_we", o_RegisterWriteEnable, 0);
    wait_to(t + 34);
    check("off70_ready", o_EventReady, 1);
    check("off70_drop_cleared", o_Dropped, 0);

    // Reset in the middle of a retrigger gap.
    send(1, 60, t);
    wait_to(t + 100);
    @(posedge clk); #1;
    i_Reset = 1'b1;
    @(posedge clk); #1;
    i_Reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", o_EventReady, 1);
    check("midrst_we", o_RegisterWriteEnable, 0);
    check("midrst_valid", o_AssignValid, 0);
    check("midrst_voice", o_AssignVoice, 0);
    send(1, 48, t);
    wait_to(t + 34);
    check("post_rst_voice", o_AssignVoice, 0);
    check("post_rst_note", o_AssignNote, 48);
    wait_idle();

    // Fill all voices, then overflow.
    do_reset();
    for (int n = 0; n < NV; n++) begin
      send(1, 10 + n, t);
      wait_idle();
    end
    send(1, 100, t);
`ifdef VOICE_STEAL_EN
    wait_to(t + 34);
    check("steal0_we", o_RegisterWriteEnable, 1);
    check("steal0_num", o_RegisterNumber, 16'h8000);
    check("steal0_val", o_RegisterValue, 8'h00);
    wait_to(t + 35 + GAP);
    check("steal0_voice", o_AssignVoice, 0);
    check("steal0_note", o_AssignNote, 100);
    wait_idle();
    send(1, 101, t);
    wait_to(t + 34);
    check("steal1_we", o_RegisterWriteEnable, 1);
    check("steal1_num", o_RegisterNumber, 16'h8001);
`else
    wait_to(t + 33);
    check("full_dropped", o_Dropped, 1);
    wait_to(t + 34);
    check("full_no_we", o_RegisterWriteEnable, 0);
    check("full_ready", o_EventReady, 1);
`endif
    wait_idle();

    // Random traffic with a randomly stalling loader.
    ar_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      rnd_on   = ($urandom_range(0, 9) < 7);
      rnd_note = 40 + int'($urandom_range(0, 39));
      send(rnd_on, rnd_note, t);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
